// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one external combinational ALU between two requesters.
// One operation every 3 cycles: handshake T, result capture T+1, response pulse T+2.
module alu_arbiter #(
    parameter int         Width   = 32,
    parameter logic [5:0] OPR_ADD = 6'b100000,
    parameter logic [5:0] OPR_SUB = 6'b100010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [Width-1:0] req0_in1,
    input  logic [Width-1:0] req0_in2,
    input  logic [5:0]       req0_aluop,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [Width-1:0] req1_in1,
    input  logic [Width-1:0] req1_in2,
    input  logic [5:0]       req1_aluop,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [Width-1:0] rsp_out,
    output logic             rsp_zero,
    output logic [Width-1:0] alu_in1,
    output logic [Width-1:0] alu_in2,
    output logic [5:0]       alu_aluop,
    input  logic [Width-1:0] alu_out,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [Width-1:0]   r_in1;
    logic [Width-1:0]   r_in2;
    logic [5:0]         r_aluop;
    logic               r_gnt;
    logic               r_ptr;
    logic [Width-1:0]   r_rsp_out;
    logic               r_rsp_zero;
    logic               w_req0_rdy;
    logic               w_req1_rdy;
    logic               w_rsp0_vld;
    logic               w_rsp1_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_ptr == 0 favours requester 0 when both are valid.
    always_comb begin
        w_state_nxt = r_state;
        w_req0_rdy  = 1'b0;
        w_req1_rdy  = 1'b0;
        w_rsp0_vld  = 1'b0;
        w_rsp1_vld  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req0_rdy = req0_valid && (!req1_valid || !r_ptr);
                w_req1_rdy = req1_valid && (!req0_valid || r_ptr);
                if (w_req0_rdy || w_req1_rdy) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: w_state_nxt = S_EXEC == r_state ? S_DONE : S_IDLE;
            S_DONE: begin
                w_rsp0_vld  = !r_gnt;
                w_rsp1_vld  = r_gnt;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Reset masks every handshake and response, including the combinational ready.
        if (reset) begin
            w_req0_rdy = 1'b0;
            w_req1_rdy = 1'b0;
            w_rsp0_vld = 1'b0;
            w_rsp1_vld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in1      <= '0;
            r_in2      <= '0;
            r_aluop    <= '0;
            r_gnt      <= 1'b0;
            r_ptr      <= 1'b0;
            r_rsp_out  <= '0;
            r_rsp_zero <= 1'b0;
        end else begin
            if (w_req0_rdy) begin
                r_in1   <= req0_in1;
                r_in2   <= req0_in2;
                r_aluop <= req0_aluop;
                r_gnt   <= 1'b0;
                r_ptr   <= 1'b1;
            end else if (w_req1_rdy) begin
                r_in1   <= req1_in1;
                r_in2   <= req1_in2;
                r_aluop <= req1_aluop;
                r_gnt   <= 1'b1;
                r_ptr   <= 1'b0;
            end
            if (r_state == S_EXEC) begin
                r_rsp_out  <= alu_out;
                r_rsp_zero <= alu_zero;
            end
        end
    end

    assign req0_ready = w_req0_rdy;
    assign req1_ready = w_req1_rdy;
    assign rsp0_valid = w_rsp0_vld;
    assign rsp1_valid = w_rsp1_vld;
    assign rsp_out    = r_rsp_out;
    assign rsp_zero   = r_rsp_zero;
    assign alu_in1    = r_in1;
    assign alu_in2    = r_in2;
    assign alu_aluop  = r_aluop;

    // Sanity checks on the attached ALU for the two opcodes this block knows by name.
    a_sub_equal_zero: assert property (@(posedge clk) disable iff (reset)
        (r_state == S_EXEC && r_aluop == OPR_SUB && r_in1 == r_in2) |=> rsp_zero);
    a_add_zero_ident: assert property (@(posedge clk) disable iff (reset)
        (r_state == S_EXEC && r_aluop == OPR_ADD && r_in2 == '0) |=> (rsp_out == r_in1));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;
    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] NOP = 6'b000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [5:0]  req0_aluop, req1_aluop, alu_aluop;
    logic        rsp0_valid, rsp1_valid, rsp_zero, alu_zero;
    logic [31:0] rsp_out, alu_in1, alu_in2, alu_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign alu_out  = (alu_aluop == ADD) ? alu_in1 + alu_in2 :
                      (alu_aluop == SUB) ? alu_in1 - alu_in2 : 32'd0;
    assign alu_zero = (alu_out == 32'd0);

    alu_arbiter #(.Width(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_aluop(req0_aluop),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_aluop(req1_aluop),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_out(rsp_out), .rsp_zero(rsp_zero),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_aluop(alu_aluop),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, b0;
        logic [5:0]  op0;
        logic [31:0] a1, b1;
        logic [5:0]  op1;
        logic        gnt;
        logic [31:0] out;
        logic        zero;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd5, 32'd7, ADD, 32'd0, 32'd0, NOP, 1'b0, 32'd12, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd0, 32'd0, NOP, 32'd9, 32'd9, SUB, 1'b1, 32'd0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'd0, 32'd1, SUB, 32'd3, 32'd4, NOP, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'd1, 32'd2, ADD, 32'd3, 32'd4, NOP, 1'b1, 32'd0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, ADD, 32'd10, 32'd20, ADD, 1'b0, 32'd0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'd7, 32'd7, ADD, 32'd10, 32'd20, ADD, 1'b1, 32'd30, 1'b0};

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_in1 = '0; req0_in2 = '0; req0_aluop = '0;
        req1_in1 = '0; req1_in2 = '0; req1_aluop = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_rsp0", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rsp_out", rsp_out, 32'd0);
        chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_aluop", {26'd0, alu_aluop}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Table: handshake cycle, EXEC cycle, DONE cycle per vector.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
            req0_in1 = vecs[i].a0; req0_in2 = vecs[i].b0; req0_aluop = vecs[i].op0;
            req1_in1 = vecs[i].a1; req1_in2 = vecs[i].b1; req1_aluop = vecs[i].op1;
            @(negedge clk);
            chk($sformatf("v%0d_ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].gnt == 1'b0});
            chk($sformatf("v%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].gnt == 1'b1});
            chk($sformatf("v%0d_idle_rsp", i), {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_exec_ready", i), {30'd0, req0_ready, req1_ready}, 32'd0);
            chk($sformatf("v%0d_exec_rsp", i), {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_ready", i), {30'd0, req0_ready, req1_ready}, 32'd0);
            chk($sformatf("v%0d_rsp0", i), {31'd0, rsp0_valid}, {31'd0, vecs[i].gnt == 1'b0});
            chk($sformatf("v%0d_rsp1", i), {31'd0, rsp1_valid}, {31'd0, vecs[i].gnt == 1'b1});
            chk($sformatf("v%0d_rsp_out", i), rsp_out, vecs[i].out);
            chk($sformatf("v%0d_rsp_zero", i), {31'd0, rsp_zero}, {31'd0, vecs[i].zero});
        end

        // Idle with nothing valid, then a valid that drops before the clock edge.
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("hold_rsp_out", rsp_out, 32'd30);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_in1 = 32'd5; req0_in2 = 32'd7; req0_aluop = ADD;
        #2 chk("pulse_ready0", {31'd0, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("pulse_dropped", {30'd0, req0_ready, req1_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_norsp%0d", k), {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_in1 = 32'd9; req1_in2 = 32'd9; req1_aluop = SUB;
        @(negedge clk);
        chk("ptr_kept_ready0", {31'd0, req0_ready}, 32'd1);
        chk("ptr_kept_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("after_abort_rsp0", {31'd0, rsp0_valid}, 32'd1);
        chk("after_abort_out", rsp_out, 32'd12);

        // Reset while in EXEC: operation dropped, pointer cleared.
        @(posedge clk); #1 req0_valid = 1'b1;
        @(negedge clk);
        chk("rexec_ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1 reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("rexec_exec_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("rexec_ready_in_rst", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("rexec_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("rexec_rsp_out", rsp_out, 32'd0);
        chk("rexec_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        chk("rexec_alu_in1", alu_in1, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        req0_in1 = 32'd1; req0_in2 = 32'd1; req0_aluop = ADD;
        req1_in1 = 32'd2; req1_in2 = 32'd2; req1_aluop = ADD;

        // Both held valid: grants 0,1,0,1 at cycles 0,3,6,9.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("alt%0d_ready0", k), {31'd0, req0_ready},
                {31'd0, (k % 3 == 0) && ((k / 3) % 2 == 0)});
            chk($sformatf("alt%0d_ready1", k), {31'd0, req1_ready},
                {31'd0, (k % 3 == 0) && ((k / 3) % 2 == 1)});
            chk($sformatf("alt%0d_rsp", k), {30'd0, rsp0_valid, rsp1_valid},
                (k % 3 != 2) ? 32'd0 : (((k / 3) % 2 == 0) ? 32'd2 : 32'd1));
            if (k % 3 == 2) begin
                chk($sformatf("alt%0d_out", k), rsp_out, ((k / 3) % 2 == 0) ? 32'd2 : 32'd4);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: Width, default 32, operand/result width in bits.
REQ-002 Parameter: OPR_ADD, default 6'b100000, add opcode (informational; all opcodes are passed through).
REQ-003 Parameter: OPR_SUB, default 6'b100010, subtract opcode (informational; all opcodes are passed through).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req0_valid  input  1  requester 0 has an operation pending.
REQ-008 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-009 req0_in1, req0_in2  input  Width  requester 0 operands.
REQ-010 req0_aluop  input  6  requester 0 opcode.
REQ-011 req1_valid, req1_ready, req1_in1, req1_in2, req1_aluop  same as req0_* for requester 1.
REQ-012 rsp0_valid  output  1  one-cycle pulse, result for requester 0 on rsp_out/rsp_zero.
REQ-013 rsp1_valid  output  1  one-cycle pulse, result for requester 1 on rsp_out/rsp_zero.
REQ-014 rsp_out  output  Width  registered ALU result.
REQ-015 rsp_zero  output  1  registered ALU zero flag.
REQ-016 alu_in1, alu_in2  output  Width  operands to the shared combinational ALU.
REQ-017 alu_aluop  output  6  opcode to the shared ALU.
REQ-018 alu_out  input  Width  ALU result.
REQ-019 alu_zero  input  1  ALU zero flag.

Function
REQ-020 The FSM SHALL have states IDLE, EXEC and DONE, encoded in a 2-bit state register.
REQ-021 In IDLE with no valid request, the FSM SHALL remain in IDLE with both ready signals low.
REQ-022 In IDLE with exactly one reqN_valid high, the block SHALL assert reqN_ready combinationally in that cycle.
REQ-023 In IDLE with both valid, the block SHALL assert ready only for the requester selected by the round-robin pointer.
REQ-024 A handshake (valid&&ready) SHALL capture that requester's in1/in2/aluop into operand registers, record the grant id, and move to EXEC.
REQ-025 The round-robin pointer SHALL point to the non-granted requester after each handshake; after reset the pointer SHALL favour requester 0.
REQ-026 The ready signals SHALL be low in EXEC and DONE.
REQ-027 alu_in1, alu_in2 and alu_aluop SHALL be driven from the operand registers at all times.
REQ-028 In EXEC, the block SHALL register alu_out into rsp_out and alu_zero into rsp_zero, then move to DONE.
REQ-029 In DONE, the block SHALL assert rspN_valid for exactly one cycle, for the recorded grant id only, and return to IDLE.
REQ-030 rsp_out and rsp_zero SHALL hold their value until the next EXEC capture.
REQ-031 Latency SHALL be: handshake in cycle T gives rspN_valid high in cycle T+2; throughput is one operation per 3 cycles.
REQ-032 A new handshake SHALL NOT occur in the DONE cycle; the earliest next handshake is cycle T+3.
REQ-033 Opcodes SHALL be forwarded unmodified, including unsupported ones (the ALU returns 0 with zero=1 for those).
REQ-034 Arithmetic SHALL wrap modulo 2^Width; the block performs no arithmetic itself.
REQ-035 A valid deasserted before handshake SHALL be ignored, with no state change and no pointer change.

Reset
REQ-036 On reset the block SHALL enter IDLE and clear the operand registers, rsp_out, rsp_zero, the grant id and the pointer (requester 0 favoured).
REQ-037 All outputs SHALL be 0 during and after reset, except alu_* outputs, which follow the cleared registers (also 0).
REQ-038 Reset in EXEC or DONE SHALL abort the operation with no rspN_valid pulse; the aborted request is not retried.
REQ-039 Reset SHALL take priority over any simultaneous handshake.

Verification
REQ-040 Reset, then req0 ADD 5,7 (opcode 6'b100000) -> req0_ready in cycle T; rsp0_valid in T+2 with rsp_out=12, rsp_zero=0, and rsp1_valid=0.
REQ-041 req1 SUB 9,9 (opcode 6'b100010) -> rsp1_valid with rsp_out=0, rsp_zero=1.
REQ-042 Both requesters held valid after reset -> grants alternate 0,1,0,1, with handshakes at T, T+3, T+6, T+9.
REQ-043 SUB 0,1 at Width=32 -> rsp_out=32'hFFFFFFFF, rsp_zero=0.
REQ-044 Opcode 6'b000000 with 3,4 -> rsp_out=0, rsp_zero=1.
REQ-045 Reset asserted in EXEC -> no rsp valid pulse, outputs 0; with both requesters then valid, the next grant is req0.
